frame_encoder_p: RTL and testbench
==================================

# frame_encoder_p

Parametrised frame formatter for the readout/transmit path: takes a 16-bit slow-control word stream framed by fst/lst/dav flags and passes the first HDR_WORDS words of each frame as zero-padded 32-bit header words. It gear-shifts the remaining 16-bit data words to 24 bits, applies an optional SEC-DED Hamming code, and emits a 32-bit framed stream with a busy (blk) flag. It sits between the clock-domain-crossing FIFO (already in clk128) and the 32-bit link serialiser. Compared with the fixed generator it adds a configurable header length, a Hamming bypass, a partial-group flush at end of frame, framing-error detection and a frame counter.

## Interface
- HDR_WORDS, 12: header words per frame, ≥1; counter width = $clog2(HDR_WORDS+1).
- HAM_EN, 1: 1 = SEC-DED parity in dato[29:24]; 0 = those bits forced to 0.
- CNT_W, 16: width of frmcnt.

- clk128  in  1  sole clock; all logic on its rising edge.
- init  in  1  reset, synchronous, active-high.
- davi  in  1  input word valid.
- fsti  in  1  first word of frame; qualified by davi.
- lsti  in  1  last word of frame; qualified by davi.
- dati  in  16  input word.
- davo  out  1  output word valid.
- fsto  out  1  first output word of frame.
- lsto  out  1  last output word of frame.
- dato  out  32  output word.
- blko  out  1  frame in progress.
- hdrerr  out  1  one-cycle framing-error pulse.
- frmcnt  out  CNT_W  count of completed frames; wraps to 0.

## Operation
- States: IDLE, HDR, DATA. init → IDLE, header counter 0, gear phase 0, gear buffer cleared. All outputs 0 while init is high and in the cycle after.
- IDLE: a davi word with fsti → header word 0 emitted, go to HDR (or stay IDLE if lsti is also set). A davi word without fsti is dropped and hdrerr pulses.
- HDR: each davi word → dato = {16'h0, dati}. The first word has fsto=1. After the HDR_WORDS-th word, go to DATA. lsti on any header word → that word carries lsto=1, go to IDLE, no data words.
- DATA: 16-bit words w0,w1,w2 per gear group, big-endian. g0 = {w0, w1[15:8]} forms on w1; g1 = {w1[7:0], w2} forms on w2. Gear phase cycles 0→1→2→0.
- Flush on lsti in DATA:
  - lsti on phase 0 word → one partial group {w0, 8'h00}.
  - lsti on phase 1 word → g0, then partial {w1[7:0], 16'h0000} on the next cycle.
  - lsti on phase 2 word → g1 only.
  - The last emitted word carries lsto=1; the block returns to IDLE.
- Encoding of a 24-bit group d:
  - Data bit j is placed at the j-th non-power-of-two position in 1..29 (3,5,6,7,9,…).
  - p[i] (i=0..4) = XOR of the data bits whose position has bit i set.
  - p[5] = XOR of d[23:0] and p[4:0].
  - dato = {2'b00, p[5:0], d}; p = 0 when HAM_EN=0.
- fsti while in HDR or DATA:
  - hdrerr pulses; pending gear data is discarded unsent.
  - No lsto is emitted for the aborted frame and frmcnt is not incremented.
  - The word becomes header word 0 of a new frame (fsto=1) and blko stays 1.
- frmcnt increments by 1 in the cycle lsto is asserted; wraps modulo 2^CNT_W.
- blko: 1 in the cycle fsto is asserted and through the cycle lsto is asserted; 0 from the following cycle.

## Timing
- All outputs are registered.
- Header word accepted in cycle N → on dato in cycle N+1.
- Data group completed in cycle N → on dato in cycle N+2, with or without Hamming. This holds for the final flush group too; a second flush word appears at N+3.
- Header→data transition: no bubble beyond the one extra pipeline cycle; outputs never collide.
- davi may be high every cycle within a frame.
- Upstream guarantees ≥2 idle cycles after a davi&lsti word before the next fsti. Violation is out of spec and is not checked by the bench.
- hdrerr is asserted in cycle N+1 for an offending word in cycle N.
- fsti&lsti on the same word → a one-word frame: fsto=lsto=1 and blko high for that single cycle.
- init mid-frame: the next cycle is IDLE with outputs 0, and frmcnt is cleared to 0.

## Test plan
- HDR_WORDS=2, HAM_EN=1; words 0xAAAA(fst), 0xBBBB, 0x0000, 0x0001, 0x0000(lst):
  - headers → 0x0000AAAA (fsto=1), 0x0000BBBB.
  - g0 = 0x000000 → dato 0x00000000.
  - flush {w1[7:0],16'h0} = 0x010000 → correctly encoded word with lsto=1.
  - frmcnt=1.
- Encode check: single group d=24'h000001 → dato 0x23000001 with HAM_EN=1; 0x00000001 with HAM_EN=0.
- Flush lengths, HDR_WORDS=1: 1, 2 and 3 data words after the header → 1, 2 and 2 data outputs respectively. Padding is zeros, lsto is on the final word only, blko falls the cycle after lsto.
- Errors:
  - davi=1 with dati=0x1234 while IDLE → no davo, hdrerr pulse.
  - fst mid-DATA with one pending word → hdrerr pulse, pending data not emitted, new fsto at N+1, frmcnt unchanged.
- fst&lst single word 0x00FF → dato 0x000000FF with fsto=lsto=blko=1 for one cycle. Run 2^CNT_W frames with CNT_W=4 → frmcnt wraps 15→0.
- init asserted during DATA → next-cycle davo=blko=lsto=0, frmcnt=0; a subsequent normal frame is emitted correctly.

Source files
------------

// File: rtl/frame_encoder_p_if.sv
// Handshake bundle between the CDC FIFO side and the frame encoder; master drives the
// 16-bit word stream in, slave (the encoder) drives the 32-bit framed stream out.
interface frame_encoder_p_if #(
  parameter int CNT_W = 16
) ();
  logic             davi;
  logic             fsti;
  logic             lsti;
  logic [15:0]      dati;
  logic             davo;
  logic             fsto;
  logic             lsto;
  logic [31:0]      dato;
  logic             blko;
  logic             hdrerr;
  logic [CNT_W-1:0] frmcnt;

  modport master (
    output davi, fsti, lsti, dati,
    input  davo, fsto, lsto, dato, blko, hdrerr, frmcnt
  );

  modport slave (
    input  davi, fsti, lsti, dati,
    output davo, fsto, lsto, dato, blko, hdrerr, frmcnt
  );
endinterface

// File: rtl/frame_encoder_p.sv
// Frame formatter: header words pass zero-padded (latency 1), data is geared 16->24 and SEC-DED coded (latency 2).
// No backpressure: accepts a word every cycle; outputs are registered and never collide within a valid frame.
module frame_encoder_p #(
  parameter int HDR_WORDS = 12,
  parameter bit HAM_EN    = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk128,
  input  logic             init,
  frame_encoder_p_if.slave io
);

  localparam int HC_W = $clog2(HDR_WORDS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [HC_W-1:0] HC_LAST   = HC_W'(HDR_WORDS - 1);
  localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1);
  localparam logic [1:0]      S_AFTER_0 = (HDR_WORDS == 1) ? S_DATA : S_HDR;

  // Parity over the 29-bit Hamming codeword; data bit j sits at the j-th
  // non-power-of-two position, so each data bit folds into the parity bits
  // selected by its position index.
  function automatic logic [5:0] ham_par(input logic [23:0] d);
    logic [4:0] p;
    logic [4:0] pos;
    logic [4:0] j;
    p = '0;
    j = '0;
    for (int n = 3; n < 30; n++) begin
      pos = 5'(n);
      if ((pos & (pos - 5'd1)) != 5'd0) begin
        p = p ^ ({5{d[j]}} & pos);
        j = j + 5'd1;
      end
    end
    return {(^d) ^ (^p), p};
  endfunction

  // Control state
  logic [1:0]      state_q,    state_d;
  logic [HC_W-1:0] hcnt_q,     hcnt_d;
  logic [1:0]      phase_q,    phase_d;
  logic [15:0]     gbuf_q,     gbuf_d;

  // Group stage between gearbox and encoder
  logic            s1_vld_q,   s1_vld_d;
  logic            s1_lst_q,   s1_lst_d;
  logic [23:0]     s1_dat_q,   s1_dat_d;
  logic            pend_vld_q, pend_vld_d;
  logic [7:0]      pend_dat_q, pend_dat_d;

  // Output registers
  logic             davo_q,    davo_d;
  logic             fsto_q,    fsto_d;
  logic             lsto_q,    lsto_d;
  logic [31:0]      dato_q,    dato_d;
  logic             blko_q,    blko_d;
  logic             hdrerr_q,  hdrerr_d;
  logic [CNT_W-1:0] frmcnt_q,  frmcnt_d;

  logic            hdr_vld;
  logic            hdr_fst;
  logic            hdr_lst;
  logic [5:0]      par;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    phase_d    = phase_q;
    gbuf_d     = gbuf_q;
    s1_vld_d   = 1'b0;
    s1_lst_d   = 1'b0;
    s1_dat_d   = s1_dat_q;
    pend_vld_d = 1'b0;
    pend_dat_d = pend_dat_q;
    hdrerr_d   = 1'b0;
    hdr_vld    = 1'b0;
    hdr_fst    = 1'b0;
    hdr_lst    = 1'b0;

    // Second half of a phase-1 flush: the leftover byte goes out one cycle late.
    if (pend_vld_q) begin
      s1_vld_d = 1'b1;
      s1_lst_d = 1'b1;
      s1_dat_d = {pend_dat_q, 16'h0000};
    end

    if (io.davi && io.fsti) begin
      // A first-word always opens a new frame; any partial frame is abandoned.
      hdrerr_d   = (state_q != S_IDLE);
      hdr_vld    = 1'b1;
      hdr_fst    = 1'b1;
      hdr_lst    = io.lsti;
      hcnt_d     = HC_ONE;
      phase_d    = 2'd0;
      gbuf_d     = '0;
      s1_vld_d   = 1'b0;
      state_d    = io.lsti ? S_IDLE : S_AFTER_0;
    end else if (io.davi) begin
      case (state_q)
        S_IDLE: begin
          hdrerr_d = 1'b1;
        end
        S_HDR: begin
          hdr_vld = 1'b1;
          hdr_lst = io.lsti;
          hcnt_d  = hcnt_q + HC_ONE;
          if (io.lsti) begin
            state_d = S_IDLE;
          end else if (hcnt_q == HC_LAST) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          case (phase_q)
            2'd0: begin
              gbuf_d  = io.dati;
              phase_d = 2'd1;
              if (io.lsti) begin
                s1_vld_d = 1'b1;
                s1_lst_d = 1'b1;
                s1_dat_d = {io.dati, 8'h00};
                phase_d  = 2'd0;
                state_d  = S_IDLE;
              end
            end
            2'd1: begin
              s1_vld_d = 1'b1;
              s1_dat_d = {gbuf_q, io.dati[15:8]};
              gbuf_d   = {8'h00, io.dati[7:0]};
              phase_d  = 2'd2;
              if (io.lsti) begin
                pend_vld_d = 1'b1;
                pend_dat_d = io.dati[7:0];
                phase_d    = 2'd0;
                state_d    = S_IDLE;
              end
            end
            default: begin
              s1_vld_d = 1'b1;
              s1_lst_d = io.lsti;
              s1_dat_d = {gbuf_q[7:0], io.dati};
              phase_d  = 2'd0;
              if (io.lsti) begin
                state_d = S_IDLE;
              end
            end
          endcase
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    par    = HAM_EN ? ham_par(s1_dat_q) : 6'd0;
    davo_d = 1'b0;
    fsto_d = 1'b0;
    lsto_d = 1'b0;
    dato_d = '0;
    // Header words take the output slot; a group still in flight at an abort is dropped.
    if (hdr_vld) begin
      davo_d = 1'b1;
      fsto_d = hdr_fst;
      lsto_d = hdr_lst;
      dato_d = {16'h0000, io.dati};
    end else if (s1_vld_q) begin
      davo_d = 1'b1;
      lsto_d = s1_lst_q;
      dato_d = {2'b00, par, s1_dat_q};
    end
    blko_d   = fsto_d | (blko_q & ~lsto_q);
    frmcnt_d = frmcnt_q + CNT_W'(lsto_d);
  end

  always_ff @(posedge clk128) begin
    if (init) begin
      state_q    <= S_IDLE;
      hcnt_q     <= '0;
      phase_q    <= 2'd0;
      gbuf_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_lst_q   <= 1'b0;
      s1_dat_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
      davo_q     <= 1'b0;
      fsto_q     <= 1'b0;
      lsto_q     <= 1'b0;
      dato_q     <= '0;
      blko_q     <= 1'b0;
      hdrerr_q   <= 1'b0;
      frmcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      phase_q    <= phase_d;
      gbuf_q     <= gbuf_d;
      s1_vld_q   <= s1_vld_d;
      s1_lst_q   <= s1_lst_d;
      s1_dat_q   <= s1_dat_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
      davo_q     <= davo_d;
      fsto_q     <= fsto_d;
      lsto_q     <= lsto_d;
      dato_q     <= dato_d;
      blko_q     <= blko_d;
      hdrerr_q   <= hdrerr_d;
      frmcnt_q   <= frmcnt_d;
    end
  end

  assign io.davo   = davo_q;
  assign io.fsto   = fsto_q;
  assign io.lsto   = lsto_q;
  assign io.dato   = dato_q;
  assign io.blko   = blko_q;
  assign io.hdrerr = hdrerr_q;
  assign io.frmcnt = frmcnt_q;

endmodule

// File: tb/tb_frame_encoder_p.sv
// Bench for frame_encoder_p: two instances (2 headers + Hamming, 1 header + bypass) share one
// input stream; a bit-stream reference model schedules the expected output of every cycle.
module tb_frame_encoder_p;

  logic        clk128 = 1'b0;
  logic        init;
  logic        davi;
  logic        fsti;
  logic        lsti;
  logic [15:0] dati;

  always #5 clk128 = ~clk128;

  frame_encoder_p_if #(.CNT_W(4)) io0 ();
  frame_encoder_p_if #(.CNT_W(4)) io1 ();

  assign io0.davi = davi;
  assign io0.fsti = fsti;
  assign io0.lsti = lsti;
  assign io0.dati = dati;
  assign io1.davi = davi;
  assign io1.fsti = fsti;
  assign io1.lsti = lsti;
  assign io1.dati = dati;

  frame_encoder_p #(.HDR_WORDS(2), .HAM_EN(1'b1), .CNT_W(4)) u_dut0 (
    .clk128 (clk128),
    .init   (init),
    .io     (io0)
  );

  frame_encoder_p #(.HDR_WORDS(1), .HAM_EN(1'b0), .CNT_W(4)) u_dut1 (
    .clk128 (clk128),
    .init   (init),
    .io     (io1)
  );

  typedef struct packed {
    logic        davo;
    logic        fsto;
    logic        lsto;
    logic        hdrerr;
    logic [31:0] dato;
  } exp_t;

  exp_t        ev[int];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  bit          cmp_en = 1'b0;
  logic        init_seen = 1'b0;

  int          hw[2]  = '{2, 1};
  bit          ham[2] = '{1'b1, 1'b0};
  bit          open_m[2];
  int          hcnt_m[2];
  logic [63:0] acc_m[2];
  int          nb_m[2];
  logic        blk_m[2];
  logic [3:0]  cnt_m[2];

  logic [15:0] fq[$];

  always @(posedge clk128) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Codeword built explicitly: positions 1..29, data at non-powers of two.
  function automatic logic [31:0] enc(input logic [23:0] g, input bit he);
    logic [29:0] code;
    logic [4:0]  p;
    int          j;
    code = '0;
    p    = '0;
    j    = 0;
    for (int pos = 1; pos < 30; pos++) begin
      if (!$onehot(pos)) begin
        code[pos] = g[j];
        j++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      for (int pos = 1; pos < 30; pos++) begin
        if (((pos >> i) & 1) == 1) p[i] = p[i] ^ code[pos];
      end
    end
    if (!he) return {8'h00, g};
    return {2'b00, (^g) ^ (^p), p, g};
  endfunction

  function automatic void add_word(input int k, input int c, input logic [31:0] w,
                                   input logic f, input logic l);
    exp_t e;
    int   key;
    key = c * 2 + k;
    e = ev.exists(key) ? ev[key] : '0;
    e.davo = 1'b1;
    e.fsto = f;
    e.lsto = l;
    e.dato = w;
    ev[key] = e;
  endfunction

  function automatic void add_err(input int k, input int c);
    exp_t e;
    int   key;
    key = c * 2 + k;
    e = ev.exists(key) ? ev[key] : '0;
    e.hdrerr = 1'b1;
    ev[key] = e;
  endfunction

  function automatic void model_step(input int k, input int n, input logic [15:0] d,
                                     input logic f, input logic l);
    logic [23:0] g;
    bit          done;
    if (f) begin
      if (open_m[k]) add_err(k, n + 1);
      add_word(k, n + 1, {16'h0000, d}, 1'b1, l);
      open_m[k] = !l;
      hcnt_m[k] = 1;
      acc_m[k]  = '0;
      nb_m[k]   = 0;
    end else if (!open_m[k]) begin
      add_err(k, n + 1);
    end else if (hcnt_m[k] < hw[k]) begin
      add_word(k, n + 1, {16'h0000, d}, 1'b0, l);
      hcnt_m[k]++;
      if (l) open_m[k] = 1'b0;
    end else begin
      acc_m[k] = (acc_m[k] << 16) | {48'h0, d};
      nb_m[k] += 16;
      done = 1'b0;
      if (nb_m[k] >= 24) begin
        g = 24'(acc_m[k] >> (nb_m[k] - 24));
        nb_m[k] -= 24;
        add_word(k, n + 2, enc(g, ham[k]), 1'b0, l && (nb_m[k] == 0));
        done = 1'b1;
      end
      if (l) begin
        if (nb_m[k] > 0) begin
          g = 24'((acc_m[k] & ((64'd1 << nb_m[k]) - 64'd1)) << (24 - nb_m[k]));
          add_word(k, done ? n + 3 : n + 2, enc(g, ham[k]), 1'b0, 1'b1);
        end
        open_m[k] = 1'b0;
        nb_m[k]   = 0;
      end
    end
  endfunction

  function automatic void model_init(input int n);
    int keys[$];
    for (int k = 0; k < 2; k++) begin
      open_m[k] = 1'b0;
      hcnt_m[k] = 0;
      acc_m[k]  = '0;
      nb_m[k]   = 0;
    end
    foreach (ev[key]) if (key / 2 > n) keys.push_back(key);
    foreach (keys[i]) ev.delete(keys[i]);
  endfunction

  // Per-cycle compare of both instances against the scheduled expectations.
  always @(negedge clk128) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        exp_t        e;
        int          key;
        logic        blk_now;
        logic [40:0] a;
        logic [40:0] x;
        key = cyc * 2 + k;
        e = ev.exists(key) ? ev[key] : '0;
        if (init_seen) begin
          blk_m[k] = 1'b0;
          cnt_m[k] = 4'd0;
        end
        blk_now  = e.fsto | blk_m[k];
        cnt_m[k] = cnt_m[k] + {3'b000, e.lsto};
        if (k == 0) a = {io0.davo, io0.fsto, io0.lsto, io0.hdrerr, io0.blko, io0.frmcnt, io0.dato};
        else        a = {io1.davo, io1.fsto, io1.lsto, io1.hdrerr, io1.blko, io1.frmcnt, io1.dato};
        if (!e.davo) a[31:0] = '0;
        x = {e.davo, e.fsto, e.lsto, e.hdrerr, blk_now, cnt_m[k], e.dato};
        check((k == 0) ? "dut0_out" : "dut1_out", {23'h0, a}, {23'h0, x});
        blk_m[k] = blk_now & ~e.lsto;
        if (ev.exists(key)) ev.delete(key);
      end
    end
    init_seen = init;
  end

  task automatic step(input logic v, input logic f, input logic l, input logic [15:0] d,
                      input logic ini);
    @(posedge clk128);
    #1;
    init = ini;
    davi = v;
    fsti = f;
    lsti = l;
    dati = d;
    if (ini) model_init(cyc);
    else if (v) for (int k = 0; k < 2; k++) model_step(k, cyc, d, f, l);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic word(input logic [15:0] d, input logic f, input logic l);
    step(1'b1, f, l, d, 1'b0);
  endtask

  task automatic send_fixed(input bit with_lst);
    for (int i = 0; i < fq.size(); i++)
      word(fq[i], i == 0, with_lst && (i == fq.size() - 1));
  endtask

  task automatic send_rand(input int nw, input bit with_lst);
    for (int i = 0; i < nw; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) idle(1);
      word(16'($urandom), i == 0, with_lst && (i == nw - 1));
    end
  endtask

  task automatic probe_zero(input string tag);
    check({tag, "_dut0"}, {59'h0, io0.davo, io0.blko, io0.lsto, io0.frmcnt == 4'd0 ? 1'b0 : 1'b1, io0.hdrerr}, 64'h0);
    check({tag, "_dut1"}, {59'h0, io1.davo, io1.blko, io1.lsto, io1.frmcnt == 4'd0 ? 1'b0 : 1'b1, io1.hdrerr}, 64'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    init = 1'b1;
    davi = 1'b0;
    fsti = 1'b0;
    lsti = 1'b0;
    dati = '0;
    repeat (3) @(posedge clk128);
    #1;
    cmp_en = 1'b1;

    // Pin the reference encoder with hand-derived codewords.
    check("enc_000001_ham", {32'h0, enc(24'h000001, 1'b1)}, 64'h23000001);
    check("enc_000001_byp", {32'h0, enc(24'h000001, 1'b0)}, 64'h00000001);
    check("enc_010000_ham", {32'h0, enc(24'h010000, 1'b1)}, 64'h16010000);
    check("enc_800000_ham", {32'h0, enc(24'h800000, 1'b1)}, 64'h3D800000);

    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    idle(1);
    @(negedge clk128);
    probe_zero("reset");

    fq = '{16'hAAAA, 16'hBBBB, 16'h0000, 16'h0001, 16'h0000};
    send_fixed(1'b1);
    idle(3);
    @(negedge clk128);
    check("frmcnt_first_dut0", {60'h0, io0.frmcnt}, 64'd1);
    check("frmcnt_first_dut1", {60'h0, io1.frmcnt}, 64'd1);

    fq = '{16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0001};
    send_fixed(1'b1);
    idle(3);

    for (int nd = 1; nd <= 3; nd++) begin
      fq = '{16'h0F00};
      for (int i = 0; i < nd; i++) fq.push_back(16'hC3A5 + 16'(i));
      send_fixed(1'b1);
      idle(3);
    end

    word(16'h1234, 1'b0, 1'b0);
    idle(2);

    fq = '{16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAB};
    send_fixed(1'b0);
    idle(1);
    fq = '{16'hBEEF, 16'h0102, 16'h0304, 16'h0506};
    send_fixed(1'b1);
    idle(3);
    @(negedge clk128);
    check("frmcnt_after_abort_dut0", {60'h0, io0.frmcnt}, 64'd6);
    check("frmcnt_after_abort_dut1", {60'h0, io1.frmcnt}, 64'd6);

    word(16'h00FF, 1'b1, 1'b1);
    idle(1);
    @(negedge clk128);
    check("single_word", {27'h0, io0.davo, io0.fsto, io0.lsto, io0.blko, io0.dato}, {27'h0, 4'hF, 32'h000000FF});
    idle(1);
    @(negedge clk128);
    check("single_blk_fall", {62'h0, io0.blko, io1.blko}, 64'h0);
    idle(1);

    fq = '{16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999};
    send_fixed(1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    idle(1);
    @(negedge clk128);
    probe_zero("init_mid");
    fq = '{16'h0A0A, 16'h0B0B, 16'h1357, 16'h9BDF, 16'h2468};
    send_fixed(1'b1);
    idle(3);

    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    idle(2);
    for (int i = 1; i <= 16; i++) begin
      word(16'h00FF, 1'b1, 1'b1);
      idle(1);
      @(negedge clk128);
      if (i == 15) check("frmcnt_15", {60'h0, io0.frmcnt}, 64'd15);
      if (i == 16) check("frmcnt_wrap", {60'h0, io0.frmcnt}, 64'd0);
      idle(1);
    end

    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        word(16'($urandom), 1'b0, 1'b0);
        idle(2);
      end else if (r < 3) begin
        send_rand($urandom_range(1, 7), 1'b0);
        idle(1 + $urandom_range(0, 1));
      end
      send_rand($urandom_range(1, 14), 1'b1);
      idle(2 + $urandom_range(0, 2));
    end

    idle(6);
    check("all_expected_seen", 64'(ev.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
